flipflop_d: RTL and testbench

FLIPFLOP_D -- requirements
Module: flipflop_d

---
 rtl/flipflop_d.sv | 50 +++++
 tb/tb_flipflop_d.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/flipflop_d.sv
// rtl/flipflop_d.sv - WIDTH-bit D flip-flop with async clear/preset; optional clock enable under FLIPFLOP_D_CLKEN_EN
module flipflop_d #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             preset,
`ifdef FLIPFLOP_D_CLKEN_EN
    input  logic             enable,
`endif
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] notout
);

    // INIT only sets the power-up value seen in simulation; clear/preset define the real reset state.
    logic [WIDTH-1:0] out_q = INIT;
    logic [WIDTH-1:0] out_d;

    // Next stored word: load data on a qualifying edge, otherwise hold.
`ifdef FLIPFLOP_D_CLKEN_EN
    always_comb begin
        out_d = out_q;
        if (enable) begin
            out_d = data;
        end
    end
`else
    always_comb begin
        out_d = data;
    end
`endif

    // Storage: clear beats preset, both act without the clock and block clock edges while low.
    always_ff @(posedge clockpulse or negedge clear or negedge preset) begin
        if (!clear) begin
            out_q <= '0;
        end else if (!preset) begin
            out_q <= '1;
        end else begin
            out_q <= out_d;
        end
    end

    // notout is derived from the same flop so the pair can never agree.
    assign out    = out_q;
    assign notout = ~out_q;

endmodule

// File: tb/tb_flipflop_d.sv
// tb/tb_flipflop_d.sv - scoreboard bench for flipflop_d (WIDTH=1 and WIDTH=8 instances)
`timescale 1ns/1ps
module tb_flipflop_d;

    logic       clockpulse;
    logic       clear;
    logic       preset;
`ifdef FLIPFLOP_D_CLKEN_EN
    logic       enable;
`endif
    logic       d1;
    logic [7:0] d8;
    logic       out1, notout1;
    logic [7:0] out8, notout8;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       e1;
        logic [7:0] e8;
    } exp_t;
    exp_t sb_q[$];

    flipflop_d #(.WIDTH(1)) u_dut1 (
        .clockpulse (clockpulse),
        .clear      (clear),
        .preset     (preset),
`ifdef FLIPFLOP_D_CLKEN_EN
        .enable     (enable),
`endif
        .data       (d1),
        .out        (out1),
        .notout     (notout1)
    );

    flipflop_d #(.WIDTH(8)) u_dut8 (
        .clockpulse (clockpulse),
        .clear      (clear),
        .preset     (preset),
`ifdef FLIPFLOP_D_CLKEN_EN
        .enable     (enable),
`endif
        .data       (d8),
        .out        (out8),
        .notout     (notout8)
    );

    // Rising edges at 100, 200, 300, ... ns
    initial begin
        clockpulse = 1'b0;
        #50;
        forever #50 clockpulse = ~clockpulse;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic push(input logic e1, input logic [7:0] e8);
        exp_t e;
        e.e1 = e1;
        e.e8 = e8;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'd0, 8'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_q1"},  {7'd0, out1},    {7'd0, e.e1});
            chk({tag, "_qn1"}, {7'd0, notout1}, {7'd0, ~e.e1});
            chk({tag, "_q8"},  out8,            e.e8);
            chk({tag, "_qn8"}, notout8,         ~e.e8);
        end
    endtask

    initial begin
        clear  = 1'b0;
        preset = 1'b1;
`ifdef FLIPFLOP_D_CLKEN_EN
        enable = 1'b1;
`endif
        d1 = 1'b0;
        d8 = 8'h00;

        // reset state
        #10 push(1'b0, 8'h00); pop_check("reset");
        #10 clear = 1'b1;

        // basic capture at 100 and 200 ns
        #70 d1 = 1'b0; d8 = 8'hA5; push(1'b0, 8'hA5);
        @(posedge clockpulse); #10 pop_check("cap0");
        #40 d1 = 1'b1; d8 = 8'h3C; push(1'b1, 8'h3C);
        @(posedge clockpulse); #10 pop_check("cap1");

        // async clear at 230 ns, edge at 300 ignored, reload at 400
        #20 clear = 1'b0; push(1'b0, 8'h00);
        #1 pop_check("clr_async");
        push(1'b0, 8'h00);
        @(posedge clockpulse); #10 pop_check("clr_edge_ign");
        #10 clear = 1'b1; push(1'b0, 8'h00);
        #10 pop_check("clr_hold");
        push(1'b1, 8'h3C);
        @(posedge clockpulse); #10 pop_check("clr_reload");

        // glitch immunity: data toggles through the high and low phases (incl. falling edge at 550)
        #40 d1 = 1'b0; d8 = 8'h00; push(1'b0, 8'h00);
        @(posedge clockpulse); #5 pop_check("glitch_cap");
        for (int i = 0; i < 9; i++) begin
            #9 d1 = ~d1; d8 = ~d8; push(1'b0, 8'h00);
            #1 pop_check("glitch");
        end
        push(1'b1, 8'hFF);
        @(posedge clockpulse); #10 pop_check("glitch_end");

        // preset, then clear overriding preset
        d1 = 1'b0; d8 = 8'h5A; push(1'b0, 8'h5A);
        @(posedge clockpulse); #10 pop_check("pre_base");
        #10 preset = 1'b0; push(1'b1, 8'hFF);
        #1 pop_check("preset_async");
        push(1'b1, 8'hFF);
        @(posedge clockpulse); #10 pop_check("preset_edge_ign");
        #10 clear = 1'b0; push(1'b0, 8'h00);
        #1 pop_check("clr_over_pre");
        #9 preset = 1'b1;
        #10 clear = 1'b1; push(1'b0, 8'h00);
        #5 pop_check("both_rel");
        d1 = 1'b1; d8 = 8'hC3; push(1'b1, 8'hC3);
        @(posedge clockpulse); #10 pop_check("post_rel");

        // falling edge at 950 must not load
        #10 d1 = 1'b0; d8 = 8'h11; push(1'b1, 8'hC3);
        #30 pop_check("fall_ign");
        push(1'b0, 8'h11);
        @(posedge clockpulse); #10 pop_check("after_fall");

`ifdef FLIPFLOP_D_CLKEN_EN
        // clock enable: hold with enable=0, load with enable=1
        enable = 1'b0; d1 = 1'b1; d8 = 8'hFF; push(1'b0, 8'h11);
        @(posedge clockpulse); #10 pop_check("en_hold");
        enable = 1'b1; push(1'b1, 8'hFF);
        @(posedge clockpulse); #10 pop_check("en_load");
`endif

        // random data
        for (int i = 0; i < 10; i++) begin
            d1 = 1'($urandom);
            d8 = 8'($urandom);
            push(d1, d8);
            @(posedge clockpulse); #10 pop_check("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
